// File: rtl/apb_i2c_regfile.sv
`timescale 1ns/1ps
// APB slave register file for the I2C controller: config registers, TX/RX byte FIFOs, maskable irq.
// Latency: 2+WAIT_STATES PCLK per transfer; the core pops TX via tx_valid/tx_ready, and RX pushes have no backpressure.
module apb_i2c_regfile #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 7
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        command_reg,
  output logic [7:0]        prescale_reg,
  output logic [7:0]        address_reg,
  input  logic [3:0]        status_in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  apb_state_t st, cur, st_nxt;
  logic [2:0] cnt, cnt_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // ACCESS is only reachable from a SETUP seen on an earlier edge, so a bus
  // caught mid-transfer by reset has to restart from SETUP.
  always_comb begin
    cur     = IDLE;
    st_nxt  = IDLE;
    cnt_nxt = cnt;
    PREADY  = 1'b0;
    if (PSELx && !PENABLE)
      cur = SETUP;
    else if (PSELx && PENABLE && st != IDLE)
      cur = ACCESS;
    PREADY = (cur == ACCESS) && (cnt == WS);
    st_nxt = PREADY ? IDLE : cur;
    case (cur)
      SETUP:   cnt_nxt = '0;
      ACCESS:  cnt_nxt = PREADY ? 3'd0 : cnt + 3'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  logic       mapped, commit;
  logic [2:0] off;
  assign mapped = (PADDR[ADDR_W-1:4] == '0) && !PADDR[3];
  assign off    = PADDR[2:0];
  assign commit = PREADY;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_wr_hit, rx_rd_hit;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign tx_wr_hit = commit && PWRITE && mapped && (off == 3'd3);
  assign rx_rd_hit = commit && !PWRITE && mapped && (off == 3'd4);
  assign tx_push   = tx_wr_hit && !tx_full;
  assign tx_pop    = tx_valid && tx_ready;
  assign rx_push   = rx_valid && !rx_full;
  assign rx_pop    = rx_rd_hit && !rx_empty;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= PWDATA;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_data;
  end

  logic [4:0] irq_en;
  logic [4:2] sticky, sticky_set, sticky_clr;

  assign sticky_set = {rx_rd_hit && rx_empty, rx_valid && rx_full, tx_wr_hit && tx_full};
  assign sticky_clr = (commit && PWRITE && mapped && off == 3'd7) ? PWDATA[4:2] : 3'b000;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      command_reg  <= '0;
      prescale_reg <= '0;
      address_reg  <= '0;
      irq_en       <= '0;
      sticky       <= '0;
    end else begin
      if (commit && PWRITE && mapped) begin
        case (off)
          3'd0:    command_reg  <= PWDATA;
          3'd1:    prescale_reg <= PWDATA;
          3'd2:    address_reg  <= PWDATA;
          3'd6:    irq_en       <= PWDATA[4:0];
          default: ;
        endcase
      end
      // set after clear: a flag raised on the W1C edge survives
      sticky <= (sticky & ~sticky_clr) | sticky_set;
    end
  end

  logic [4:0] irq_stat;
  logic [7:0] rdata;
  logic       err;
  assign irq_stat = {sticky, !rx_empty, tx_empty};
  assign irq      = |(irq_stat & irq_en);

  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (off)
        3'd0:    rdata = command_reg;
        3'd1:    rdata = prescale_reg;
        3'd2:    rdata = address_reg;
        3'd4:    rdata = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
        3'd5:    rdata = {status_in, rx_full, rx_empty, tx_full, tx_empty};
        3'd6:    rdata = {3'b000, irq_en};
        3'd7:    rdata = {3'b000, irq_stat};
        default: rdata = '0;
      endcase
    end
  end

  assign err     = !mapped || (PWRITE && off == 3'd3 && tx_full) || (!PWRITE && off == 3'd4 && rx_empty);
  assign PRDATA  = PREADY ? rdata : 8'h00;
  assign PSLVERR = PREADY && err;
endmodule
